// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Push-button conditioning ahead of the priority encoder.
//             Each channel has a 2-flop synchronizer and a saturating
//             stability counter. A new level is accepted only after
//             CNT_MAX consecutive synchronized samples disagree with the
//             current debounced level.
//  Options  : define BTN_DEBOUNCE_RISE_EN to make btn_rise a registered
//             one-cycle press strobe. Without it, btn_rise is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int N_BTN   = 4,
   parameter int CNT_MAX = 100000,
   parameter int CNT_W   = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_rise,
   output logic             btn_any
);

   // Last counter value before a differing level is accepted
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [N_BTN-1:0] r_db;
   logic             r_any;
   logic [N_BTN-1:0] w_db_next;

   // Two-stage metastability filter; nothing between the stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             w_lvl_next;

      // Count disagreeing samples; any agreement restarts the window
      always_comb begin
         w_lvl_next = r_db[gi];
         w_cnt_next = '0;
         if (r_sync2[gi] != r_db[gi]) begin
            if (r_cnt >= C_CNT_LAST) begin
               w_lvl_next = r_sync2[gi];
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
      end

      // Per-channel stability counter
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_next;
         end
      end

      assign w_db_next[gi] = w_lvl_next;
   end

   // Debounced levels and their OR, updated on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db  <= '0;
         r_any <= 1'b0;
      end else begin
         r_db  <= w_db_next;
         r_any <= |w_db_next;
      end
   end

   assign btn_db  = r_db;
   assign btn_any = r_any;

`ifdef BTN_DEBOUNCE_RISE_EN
   logic [N_BTN-1:0] r_rise;

   // Press strobe, high in the first cycle of a newly accepted 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise <= '0;
      end else begin
         r_rise <= w_db_next & ~r_db;
      end
   end

   assign btn_rise = r_rise;
`else
   assign btn_rise = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_debounce
//  Purpose  : Self-checking bench for btn_debounce (CNT_MAX=8, CNT_W=4).
//             A window-based reference model predicts every cycle's
//             outputs into a scoreboard queue; hand sequences cover the
//             reset, glitch-ceiling and asynchronous-reset corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

`ifdef BTN_DEBOUNCE_RISE_EN
   localparam bit RISE_EN = 1'b1;
`else
   localparam bit RISE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] db;
      logic [3:0] rise;
      logic       any;
   } exp_t;

   typedef struct {
      logic [3:0] raw;
      int         cyc;
      logic [3:0] db;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_raw = 4'hF;
   logic [3:0] btn_db;
   logic [3:0] btn_rise;
   logic       btn_any;

   int n_chk = 0;
   int n_err = 0;
   int rise_cnt [4];

   // Reference model state: pipeline plus last 8 synchronized samples
   logic [3:0] m_s1, m_s2, m_db;
   logic [7:0] m_hist [4];
   exp_t       sb_q [$];
   vec_t       tbl [$];

   btn_debounce #(.N_BTN(4), .CNT_MAX(8), .CNT_W(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_any  (btn_any)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [3:0] raw, input int cyc, input logic [3:0] db);
      vec_t v;
      v.raw = raw;
      v.cyc = cyc;
      v.db  = db;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_db = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
   endtask

   // A level flips once the last 8 evaluated samples all disagree with it
   task automatic model_edge(input logic [3:0] raw, input logic r, output exp_t e);
      logic [3:0] nd;
      if (r) begin
         model_reset();
         e = '0;
      end else begin
         nd = m_db;
         for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][6:0], m_s2[i]};
            if (m_hist[i] == {8{~m_db[i]}}) nd[i] = ~m_db[i];
         end
         e.db   = nd;
         e.rise = RISE_EN ? (nd & ~m_db) : 4'b0000;
         e.any  = |nd;
         m_db = nd;
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   // Drive one cycle, predict, then compare one time unit after the edge
   task automatic step(input logic [3:0] raw, input logic r);
      exp_t e;
      btn_raw = raw;
      rst     = r;
      model_edge(raw, r, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("sb_db", 32'(btn_db), 32'(e.db));
      chk("sb_rise", 32'(btn_rise), 32'(e.rise));
      chk("sb_any", 32'(btn_any), 32'(e.any));
      for (int i = 0; i < 4; i++) rise_cnt[i] += int'(btn_rise[i]);
   endtask

   initial begin
      int first;
      int seen;
      int hi_cnt;

      model_reset();
      for (int i = 0; i < 4; i++) rise_cnt[i] = 0;

      // Reset held with all buttons pressed, then release
      for (int k = 0; k < 5; k++) step(4'hF, 1'b1);
      chk("t1_rst_db", 32'(btn_db), 32'h0);
      chk("t1_rst_any", 32'(btn_any), 32'h0);
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         step(4'hF, 1'b0);
         if (first == 0 && btn_db == 4'hF) first = k;
      end
      chk("t1_accept_edge", 32'(first), 32'd10);
      chk("t1_any", 32'(btn_any), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("t1_rise_pulses", 32'(rise_cnt[i]), RISE_EN ? 32'd1 : 32'd0);
         rise_cnt[i] = 0;
      end

      // Release of test 1, clean press (2), bounce (3), simultaneous (4)
      tbl.push_back(mk(4'h0, 9, 4'hF));
      tbl.push_back(mk(4'h0, 1, 4'h0));
      tbl.push_back(mk(4'h4, 9, 4'h0));
      tbl.push_back(mk(4'h4, 1, 4'h4));
      tbl.push_back(mk(4'h4, 10, 4'h4));
      tbl.push_back(mk(4'h0, 9, 4'h4));
      tbl.push_back(mk(4'h0, 1, 4'h0));
      for (int b = 0; b < 3; b++) begin
         tbl.push_back(mk(4'h2, 5, 4'h0));
         tbl.push_back(mk(4'h0, 2, 4'h0));
      end
      tbl.push_back(mk(4'h2, 9, 4'h0));
      tbl.push_back(mk(4'h2, 1, 4'h2));
      tbl.push_back(mk(4'h0, 9, 4'h2));
      tbl.push_back(mk(4'h0, 1, 4'h0));
      tbl.push_back(mk(4'h9, 5, 4'h0));
      tbl.push_back(mk(4'h8, 1, 4'h0));
      tbl.push_back(mk(4'h9, 3, 4'h0));
      tbl.push_back(mk(4'h9, 1, 4'h8));
      tbl.push_back(mk(4'h9, 5, 4'h8));
      tbl.push_back(mk(4'h9, 1, 4'h9));
      tbl.push_back(mk(4'h0, 9, 4'h9));
      tbl.push_back(mk(4'h0, 1, 4'h0));

      foreach (tbl[v]) begin
         for (int k = 0; k < tbl[v].cyc; k++) step(tbl[v].raw, 1'b0);
         chk($sformatf("tbl%0d_db", v), 32'(btn_db), 32'(tbl[v].db));
      end
      for (int i = 0; i < 4; i++)
         chk("tbl_rise_pulses", 32'(rise_cnt[i]), RISE_EN ? 32'd1 : 32'd0);

      // Asynchronous reset in the middle of a count
      for (int k = 0; k < 10; k++) step(4'h8, 1'b0);
      chk("t5_pre_db", 32'(btn_db), 32'h8);
      for (int k = 0; k < 7; k++) step(4'hA, 1'b0);
      chk("t5_mid_db", 32'(btn_db), 32'h8);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_db", 32'(btn_db), 32'h0);
      chk("t5_async_any", 32'(btn_any), 32'h0);
      model_reset();
      for (int k = 0; k < 3; k++) step(4'hA, 1'b1);
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         step(4'hA, 1'b0);
         if (first == 0 && btn_db == 4'hA) first = k;
      end
      chk("t5_accept_edge", 32'(first), 32'd10);

      // Glitch ceiling: 7 samples rejected, 8 accepted
      for (int k = 0; k < 12; k++) step(4'h0, 1'b0);
      chk("t6_clear_db", 32'(btn_db), 32'h0);
      seen = 0;
      for (int k = 0; k < 7; k++) begin
         step(4'h1, 1'b0);
         if (btn_db[0]) seen++;
      end
      for (int k = 0; k < 12; k++) begin
         step(4'h0, 1'b0);
         if (btn_db[0]) seen++;
      end
      chk("t6_seven_seen", 32'(seen), 32'd0);
      first  = 0;
      hi_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         step((k <= 8) ? 4'h1 : 4'h0, 1'b0);
         if (btn_db[0]) begin
            hi_cnt++;
            if (first == 0) first = k;
         end
      end
      chk("t6_eight_first", 32'(first), 32'd10);
      chk("t6_eight_width", 32'(hi_cnt), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
